// File: rtl/align_seq_ctrl.sv
// align_seq_ctrl: sequencer for the background-elimination stream aligner.
// Snoops the live and reference AXI-Stream handshakes, captures one reference
// frame after camera settling, then enables the aligner. A tuser misalignment
// watchdog in RUN forces a re-capture.
// Optional per-frame beat-count check: define ALIGN_SEQ_PIXCHK_EN.
module align_seq_ctrl #(
    parameter int FRAME_PIXELS = 307200,
    parameter int SKIP_FRAMES  = 2,
    parameter int SYNC_TIMEOUT = 4096,
    parameter int ERR_W        = 8,
    localparam int ADDR_W      = $clog2(FRAME_PIXELS)
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              start,
    input  logic              stop,
    input  logic              recapture,
    input  logic              tvalid_new,
    input  logic              tready_new,
    input  logic              tuser_new,
    input  logic              tvalid_ref,
    input  logic              tready_ref,
    input  logic              tuser_ref,
    output logic              align_enable,
    output logic              ref_wr_en,
    output logic [ADDR_W-1:0] ref_wr_addr,
    output logic              capture_done,
    output logic              cap_err,
    output logic [ERR_W-1:0]  sync_err_cnt,
    output logic [15:0]       frame_cnt,
    output logic [2:0]        state_o,
    output logic [ERR_W-1:0]  len_err_cnt
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] SETTLE  = 3'd1;
    localparam logic [2:0] CAPTURE = 3'd2;
    localparam logic [2:0] RUN     = 3'd3;
    localparam logic [2:0] RESYNC  = 3'd4;

    localparam int SOF_W = $clog2(SKIP_FRAMES + 2);
    localparam int MM_W  = $clog2(SYNC_TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);
    localparam logic [SOF_W-1:0]  SKIP_VAL  = SOF_W'(SKIP_FRAMES);
    localparam logic [MM_W-1:0]   MM_LAST   = MM_W'(SYNC_TIMEOUT - 1);

    logic [2:0]        state_q, state_d;
    logic [SOF_W-1:0]  sof_cnt_q, sof_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [MM_W-1:0]   mm_cnt_q, mm_cnt_d;
    logic [ERR_W-1:0]  sync_err_q, sync_err_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              done_q, done_d;
    logic              cap_err_q, cap_err_d;
    logic              align_q, align_d;

    logic new_beat, ref_beat, sof_new, mismatch, timeout;
    logic settle_entry, cap_restart;

    assign new_beat = tvalid_new & tready_new;
    assign ref_beat = tvalid_ref & tready_ref;
    assign sof_new  = new_beat & tuser_new;
    assign mismatch = tuser_new ^ tuser_ref;
    assign timeout  = (state_q == RUN) && mismatch && (mm_cnt_q == MM_LAST);

    // SOF that ends settling, and an early SOF that restarts a partial capture
    assign settle_entry = (state_q == SETTLE) && sof_new && (sof_cnt_q == SKIP_VAL);
    assign cap_restart  = (state_q == CAPTURE) && sof_new && (addr_q != LAST_ADDR);

    // Write strobe follows the live handshake; an aborting stop suppresses it
    assign ref_wr_en = !stop && (settle_entry || ((state_q == CAPTURE) && new_beat));

    // addr_q holds the index of the expected beat; a restarting SOF lands at 0
    assign ref_wr_addr = ((state_q == CAPTURE) && !cap_restart) ? addr_q : '0;

    // Next-state and counter update; stop pre-empts everything, timeout beats recapture
    always_comb begin
        state_d     = state_q;
        sof_cnt_d   = sof_cnt_q;
        addr_d      = addr_q;
        mm_cnt_d    = '0;
        sync_err_d  = sync_err_q;
        frame_cnt_d = frame_cnt_q;
        done_d      = 1'b0;
        cap_err_d   = 1'b0;
        if (stop) begin
            state_d  = IDLE;
            mm_cnt_d = mm_cnt_q;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d   = SETTLE;
                        sof_cnt_d = '0;
                    end
                end
                SETTLE: begin
                    addr_d = '0;
                    if (settle_entry) begin
                        state_d = CAPTURE;
                        addr_d  = ADDR_W'(1);
                    end else if (sof_new) begin
                        sof_cnt_d = sof_cnt_q + 1'b1;
                    end
                end
                CAPTURE: begin
                    if (new_beat) begin
                        if (cap_restart) begin
                            cap_err_d = 1'b1;
                            addr_d    = ADDR_W'(1);
                        end else if (addr_q == LAST_ADDR) begin
                            done_d  = 1'b1;
                            state_d = RUN;
                            addr_d  = '0;
                        end else begin
                            addr_d = addr_q + 1'b1;
                        end
                    end
                end
                RUN: begin
                    mm_cnt_d = mismatch ? mm_cnt_q + 1'b1 : '0;
                    if (sof_new && ref_beat && tuser_ref)
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    if (timeout) begin
                        state_d  = RESYNC;
                        mm_cnt_d = '0;
                        if (sync_err_q != '1)
                            sync_err_d = sync_err_q + 1'b1;
                    end else if (recapture) begin
                        state_d = RESYNC;
                    end
                end
                RESYNC: begin
                    state_d   = SETTLE;
                    sof_cnt_d = '0;
                end
                default: state_d = IDLE;
            endcase
        end
        align_d = (state_d == RUN);
    end

    // Sequencer state and counters
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            sof_cnt_q   <= '0;
            addr_q      <= '0;
            mm_cnt_q    <= '0;
            sync_err_q  <= '0;
            frame_cnt_q <= '0;
            done_q      <= 1'b0;
            cap_err_q   <= 1'b0;
            align_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sof_cnt_q   <= sof_cnt_d;
            addr_q      <= addr_d;
            mm_cnt_q    <= mm_cnt_d;
            sync_err_q  <= sync_err_d;
            frame_cnt_q <= frame_cnt_d;
            done_q      <= done_d;
            cap_err_q   <= cap_err_d;
            align_q     <= align_d;
        end
    end

    assign align_enable = align_q;
    assign capture_done = done_q;
    assign cap_err      = cap_err_q;
    assign sync_err_cnt = sync_err_q;
    assign frame_cnt    = frame_cnt_q;
    assign state_o      = state_q;

`ifdef ALIGN_SEQ_PIXCHK_EN
    localparam int PIX_W = $clog2(FRAME_PIXELS + 1) + 1;
    localparam logic [PIX_W-1:0] PIX_FULL = PIX_W'(FRAME_PIXELS);

    logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [ERR_W-1:0] len_err_q, len_err_d;

    // Beats per RUN frame; count saturates so a missing SOF cannot wrap to a legal length
    always_comb begin
        pix_cnt_d = pix_cnt_q;
        len_err_d = len_err_q;
        if (state_q != RUN) begin
            pix_cnt_d = '0;
        end else if (!stop && new_beat) begin
            if (sof_new) begin
                pix_cnt_d = PIX_W'(1);
                if ((pix_cnt_q != '0) && (pix_cnt_q != PIX_FULL) && (len_err_q != '1))
                    len_err_d = len_err_q + 1'b1;
            end else if (pix_cnt_q != '1) begin
                pix_cnt_d = pix_cnt_q + 1'b1;
            end
        end
    end

    // Frame length checker state
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pix_cnt_q <= '0;
            len_err_q <= '0;
        end else begin
            pix_cnt_q <= pix_cnt_d;
            len_err_q <= len_err_d;
        end
    end

    assign len_err_cnt = len_err_q;
`else
    assign len_err_cnt = '0;
`endif

endmodule
